// File: rtl/rv_boot_loader.sv
// rv_boot_loader: receives a byte stream (16-bit word count, little-endian
// payload, XOR checksum), writes the assembled words into instruction memory
// and holds the core in reset until the image has been verified.
module rv_boot_loader #(
  parameter int unsigned Width       = 32,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [Width-1:0] imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_reset,
  output logic             done,
  output logic             err
);

  // word_idx must be able to reach DEPTH_WORDS after the final increment
  localparam int unsigned IdxW = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_LOAD,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [7:0]      cnt_lo_q;
  logic [15:0]     count_q;
  logic [IdxW-1:0] word_idx_q;
  logic [1:0]      byte_idx_q;
  logic [7:0]      xor_q;
  logic [23:0]     shift_q;
  logic            we_q;

  logic            accept;
  logic [15:0]     hdr_count;
  logic            hdr_bad;
  logic            last_word;

  assign accept    = in_valid && in_ready;
  assign hdr_count = {in_data, cnt_lo_q};
  assign hdr_bad   = (hdr_count == 16'd0) || (hdr_count > 16'(DEPTH_WORDS));
  assign last_word = (byte_idx_q == 2'd3) && (16'(word_idx_q) == (count_q - 16'd1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HDR0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; RUN and ERROR are terminal
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR0: if (accept) state_d = S_HDR1;
      S_HDR1: if (accept) state_d = hdr_bad ? S_ERROR : S_LOAD;
      S_LOAD: if (accept && last_word) state_d = S_CSUM;
      S_CSUM: if (accept) state_d = (in_data == xor_q) ? S_RUN : S_ERROR;
      default: ;
    endcase
  end

  // State-decoded outputs; a write strobe still pending when reset rises is dropped
  always_comb begin
    in_ready   = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    imem_we    = we_q && !reset;
    unique case (state_q)
      S_HDR0, S_HDR1, S_LOAD, S_CSUM: in_ready = !reset;
      S_RUN: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      S_ERROR: err = 1'b1;
      default: ;
    endcase
  end

  // Header capture, word assembly, running checksum and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_lo_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      xor_q      <= '0;
      shift_q    <= '0;
      we_q       <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        unique case (state_q)
          S_HDR0: cnt_lo_q <= in_data;
          S_HDR1: begin
            count_q    <= hdr_count;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            xor_q      <= '0;
          end
          S_LOAD: begin
            xor_q      <= xor_q ^ in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              we_q       <= 1'b1;
              imem_addr  <= Width'({word_idx_q, 2'b00});
              imem_wdata <= {in_data, shift_q};
              word_idx_q <= word_idx_q + IdxW'(1);
            end else begin
              shift_q <= {in_data, shift_q[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_boot_loader.sv
// Self-checking bench for rv_boot_loader: table of image scenarios, random
// images checked against a stream-level reference model, and hand-written
// timing, mid-load reset and post-RUN sequences.
module tb_rv_boot_loader;

  localparam int unsigned Width = 32;
  localparam int unsigned Depth = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             imem_we;
  logic [Width-1:0] imem_addr;
  logic [31:0]      imem_wdata;
  logic             core_reset;
  logic             done;
  logic             err;

  rv_boot_loader #(.Width(Width), .DEPTH_WORDS(Depth)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string name;
    int    kind;      // 0: fixed example image, 1: generated image
    int    n_hdr;
    bit    bad_csum;
    bit    thr;
    bit    exp_done;
  } vec_t;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] stream[$];
  vec_t       tbl[9];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Capture every write strobe away from the active edge
  always @(negedge clk) begin
    if (imem_we) got_q.push_back('{imem_addr, imem_wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Present one byte and hold it until accepted; returns at the negedge after acceptance
  task automatic send(input logic [7:0] b, input bit thr);
    int t;
    t = 0;
    if (thr) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic build(input int kind, input int n_hdr, input bit bad_csum);
    logic [15:0] n16;
    logic [7:0]  x;
    logic [7:0]  b;
    stream.delete();
    if (kind == 0) begin
      stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                 8'h33, 8'h81, 8'h10, 8'h00, 8'h61};
      if (bad_csum) stream[10] = stream[10] ^ 8'h01;
    end else begin
      n16 = 16'(n_hdr);
      stream.push_back(n16[7:0]);
      stream.push_back(n16[15:8]);
      if (n_hdr >= 1 && n_hdr <= int'(Depth)) begin
        x = 8'h00;
        for (int i = 0; i < 4 * n_hdr; i++) begin
          b = 8'($urandom);
          x = x ^ b;
          stream.push_back(b);
        end
        stream.push_back(x ^ {7'd0, bad_csum});
      end
    end
  endtask

  // Expected writes derived from the stream format alone
  task automatic model();
    int n;
    exp_q.delete();
    n = int'({stream[1], stream[0]});
    if (n == 0 || n > int'(Depth)) return;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{32'(4 * i),
                        {stream[2 + 4 * i + 3], stream[2 + 4 * i + 2],
                         stream[2 + 4 * i + 1], stream[2 + 4 * i]}});
    end
  endtask

  task automatic run_case(input string name, input bit thr, input bit exp_done, input bit rst);
    int nw;
    if (rst) do_reset();
    got_q.delete();
    model();
    foreach (stream[i]) send(stream[i], thr);
    chk({name, ":done_next_cycle"}, 32'(done), 32'(exp_done));
    chk({name, ":err_next_cycle"}, 32'(err), 32'(!exp_done));
    repeat (2) @(negedge clk);
    #1;
    chk({name, ":nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    nw = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("%s:addr%0d", name, i), got_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s:data%0d", name, i), got_q[i].data, exp_q[i].data);
    end
    chk({name, ":done"}, 32'(done), 32'(exp_done));
    chk({name, ":err"}, 32'(err), 32'(!exp_done));
    chk({name, ":core_reset"}, 32'(core_reset), 32'(!exp_done));
    chk({name, ":in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic set_vec(input int i, input string name, input int kind, input int n_hdr,
                         input bit bad, input bit thr, input bit exp_done);
    tbl[i].name     = name;
    tbl[i].kind     = kind;
    tbl[i].n_hdr    = n_hdr;
    tbl[i].bad_csum = bad;
    tbl[i].thr      = thr;
    tbl[i].exp_done = exp_done;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    set_vec(0, "fixed_good",     0, 2,     0, 0, 1);
    set_vec(1, "fixed_badcsum",  0, 2,     1, 0, 0);
    set_vec(2, "hdr_zero",       1, 0,     0, 0, 0);
    set_vec(3, "hdr_65",         1, 65,    0, 0, 0);
    set_vec(4, "hdr_256",        1, 256,   0, 0, 0);
    set_vec(5, "full_64",        1, 64,    0, 0, 1);
    set_vec(6, "single_word",    1, 1,     0, 0, 1);
    set_vec(7, "fixed_throttle", 0, 2,     0, 1, 1);
    set_vec(8, "rand_bad_thr",   1, 3,     1, 1, 0);

    // Reset values
    do_reset();
    chk("rst:core_reset", 32'(core_reset), 32'd1);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:err", 32'(err), 32'd0);
    chk("rst:imem_we", 32'(imem_we), 32'd0);
    chk("rst:imem_addr", imem_addr, 32'd0);
    chk("rst:imem_wdata", imem_wdata, 32'd0);
    chk("rst:in_ready", 32'(in_ready), 32'd1);

    // Table-driven scenarios
    for (int i = 0; i < 9; i++) begin
      build(tbl[i].kind, tbl[i].n_hdr, tbl[i].bad_csum);
      run_case(tbl[i].name, tbl[i].thr, tbl[i].exp_done, 1'b1);
    end

    // Random images, throttled, checked against the model
    for (int r = 0; r < 4; r++) begin
      bit bad;
      int n;
      bad = 1'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 8));
      build(1, n, bad);
      run_case($sformatf("rand%0d", r), 1'b1, !bad, 1'b1);
    end

    // Exact write timing on the example image, then post-RUN bytes
    do_reset();
    got_q.delete();
    build(0, 2, 1'b0);
    for (int i = 0; i < 6; i++) send(stream[i], 1'b0);
    #1;
    chk("seq:we0", 32'(imem_we), 32'd1);
    chk("seq:addr0", imem_addr, 32'h0);
    chk("seq:data0", imem_wdata, 32'h0050_0093);
    for (int i = 6; i < 10; i++) send(stream[i], 1'b0);
    #1;
    chk("seq:we1", 32'(imem_we), 32'd1);
    chk("seq:addr1", imem_addr, 32'h4);
    chk("seq:data1", imem_wdata, 32'h0010_8133);
    chk("seq:core_reset_before_csum", 32'(core_reset), 32'd1);
    send(stream[10], 1'b0);
    #1;
    chk("seq:done_after_csum", 32'(done), 32'd1);
    chk("seq:core_reset_after_csum", 32'(core_reset), 32'd0);
    chk("seq:we_after_csum", 32'(imem_we), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post:in_ready%0d", c), 32'(in_ready), 32'd0);
      chk($sformatf("post:we%0d", c), 32'(imem_we), 32'd0);
      chk($sformatf("post:done%0d", c), 32'(done), 32'd1);
      chk($sformatf("post:core_reset%0d", c), 32'(core_reset), 32'd0);
    end
    in_valid = 1'b0;
    chk("post:nwrites", 32'(got_q.size()), 32'd2);

    // Reset mid-load right after word 0 completes, then reload
    do_reset();
    build(0, 2, 1'b0);
    for (int i = 0; i < 6; i++) send(stream[i], 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst:we_during", 32'(imem_we), 32'd0);
    chk("midrst:in_ready_during", 32'(in_ready), 32'd0);
    chk("midrst:core_reset_during", 32'(core_reset), 32'd1);
    chk("midrst:done_during", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst:we_after", 32'(imem_we), 32'd0);
    chk("midrst:core_reset_after", 32'(core_reset), 32'd1);
    chk("midrst:done_after", 32'(done), 32'd0);
    chk("midrst:addr_after", imem_addr, 32'd0);
    chk("midrst:in_ready_after", 32'(in_ready), 32'd1);
    run_case("midrst_reload", 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
